// File: rtl/pipelined_controller.sv
// ID-stage control unit for the pipelined MIPS datapath.
// Decodes the opcode into a registered control word at the ID/EX boundary.
// It inserts bubbles for load-use hazards and branch flushes, flags illegal
// opcodes, and holds the front end in stall while a multi-cycle MUL sits in EX.
// state_dbg is 1 while the sequencer is BUSY.
module pipelined_controller #(
  parameter int OP_CODE_LEN = 6,
  parameter int EXE_CMD_LEN = 4,
  parameter int MUL_CYCLES  = 4,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OP_CODE_LEN-1:0] opCode,
  input  logic                   hazard_detected,
  input  logic                   flush,
  output logic                   branchEn,
  output logic                   Is_Imm,
  output logic                   ST_or_BNE,
  output logic                   WB_EN,
  output logic                   MEM_R_EN,
  output logic                   MEM_W_EN,
  output logic [EXE_CMD_LEN-1:0] EXE_CMD,
  output logic [1:0]             Branch_command,
  output logic                   stall_out,
  output logic                   illegal_op,
  output logic [CNT_W-1:0]       bubble_cnt,
  output logic                   state_dbg
);

  localparam logic [OP_CODE_LEN-1:0] OP_NOP = OP_CODE_LEN'(0);
  localparam logic [OP_CODE_LEN-1:0] OP_ADD = OP_CODE_LEN'(1);
  localparam logic [OP_CODE_LEN-1:0] OP_SUB = OP_CODE_LEN'(2);
  localparam logic [OP_CODE_LEN-1:0] OP_AND = OP_CODE_LEN'(3);
  localparam logic [OP_CODE_LEN-1:0] OP_OR  = OP_CODE_LEN'(4);
  localparam logic [OP_CODE_LEN-1:0] OP_BEZ = OP_CODE_LEN'(5);
  localparam logic [OP_CODE_LEN-1:0] OP_BNE = OP_CODE_LEN'(6);
  localparam logic [OP_CODE_LEN-1:0] OP_JMP = OP_CODE_LEN'(7);
  localparam logic [OP_CODE_LEN-1:0] OP_LD  = OP_CODE_LEN'(8);
  localparam logic [OP_CODE_LEN-1:0] OP_ST  = OP_CODE_LEN'(9);
  localparam logic [OP_CODE_LEN-1:0] OP_MUL = OP_CODE_LEN'(10);

  localparam logic [EXE_CMD_LEN-1:0] EXE_ADD = EXE_CMD_LEN'(1);
  localparam logic [EXE_CMD_LEN-1:0] EXE_SUB = EXE_CMD_LEN'(2);
  localparam logic [EXE_CMD_LEN-1:0] EXE_AND = EXE_CMD_LEN'(3);
  localparam logic [EXE_CMD_LEN-1:0] EXE_OR  = EXE_CMD_LEN'(4);
  localparam logic [EXE_CMD_LEN-1:0] EXE_MUL = EXE_CMD_LEN'(5);

  localparam logic [7:0]       MC_LOAD = 8'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state, state_n;
  logic [7:0]             mc, mc_n;
  logic                   br_n, imm_n, st_n, wb_n, mr_n, mw_n;
  logic [EXE_CMD_LEN-1:0] exe_n;
  logic [1:0]             bc_n;
  logic                   stall_n, ill_n, bubble, decode_en;
  logic [CNT_W-1:0]       cnt_n;

  assign state_dbg = (state == BUSY);

  // Next state, MUL countdown and next control word; decoding also runs on the
  // last BUSY edge (mc==1) so the instruction held behind a MUL issues at once.
  always_comb begin
    state_n   = state;
    mc_n      = mc;
    br_n      = 1'b0;
    imm_n     = 1'b0;
    st_n      = 1'b0;
    wb_n      = 1'b0;
    mr_n      = 1'b0;
    mw_n      = 1'b0;
    exe_n     = '0;
    bc_n      = 2'd0;
    stall_n   = 1'b0;
    ill_n     = 1'b0;
    bubble    = 1'b0;
    decode_en = (state == IDLE) || (mc == 8'd1);
    if (state == BUSY) begin
      mc_n    = mc - 8'd1;
      stall_n = 1'b1;
      if (mc == 8'd1) begin
        state_n = IDLE;
        stall_n = 1'b0;
      end
    end
    if (decode_en) begin
      if (flush || hazard_detected) begin
        bubble = 1'b1;
      end else begin
        case (opCode)
          OP_NOP: ;
          OP_ADD: begin exe_n = EXE_ADD; wb_n = 1'b1; end
          OP_SUB: begin exe_n = EXE_SUB; wb_n = 1'b1; end
          OP_AND: begin exe_n = EXE_AND; wb_n = 1'b1; end
          OP_OR:  begin exe_n = EXE_OR;  wb_n = 1'b1; end
          OP_BEZ: begin imm_n = 1'b1; br_n = 1'b1; bc_n = 2'd1; end
          OP_BNE: begin imm_n = 1'b1; br_n = 1'b1; bc_n = 2'd2; st_n = 1'b1; end
          OP_JMP: begin imm_n = 1'b1; br_n = 1'b1; bc_n = 2'd3; end
          OP_LD:  begin exe_n = EXE_ADD; imm_n = 1'b1; wb_n = 1'b1; mr_n = 1'b1; end
          OP_ST:  begin exe_n = EXE_ADD; imm_n = 1'b1; st_n = 1'b1; mw_n = 1'b1; end
          OP_MUL: begin
            exe_n = EXE_MUL;
            wb_n  = 1'b1;
            if (MC_LOAD != 8'd0) begin
              state_n = BUSY;
              mc_n    = MC_LOAD;
              stall_n = 1'b1;
            end
          end
          default: begin ill_n = 1'b1; bubble = 1'b1; end
        endcase
      end
    end
    cnt_n = bubble_cnt;
    if (bubble && (bubble_cnt != CNT_MAX)) cnt_n = bubble_cnt + CNT_W'(1);
  end

  // ID/EX register: state, countdown, control word and bubble counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      mc             <= 8'd0;
      branchEn       <= 1'b0;
      Is_Imm         <= 1'b0;
      ST_or_BNE      <= 1'b0;
      WB_EN          <= 1'b0;
      MEM_R_EN       <= 1'b0;
      MEM_W_EN       <= 1'b0;
      EXE_CMD        <= '0;
      Branch_command <= 2'd0;
      stall_out      <= 1'b0;
      illegal_op     <= 1'b0;
      bubble_cnt     <= '0;
    end else begin
      state          <= state_n;
      mc             <= mc_n;
      branchEn       <= br_n;
      Is_Imm         <= imm_n;
      ST_or_BNE      <= st_n;
      WB_EN          <= wb_n;
      MEM_R_EN       <= mr_n;
      MEM_W_EN       <= mw_n;
      EXE_CMD        <= exe_n;
      Branch_command <= bc_n;
      stall_out      <= stall_n;
      illegal_op     <= ill_n;
      bubble_cnt     <= cnt_n;
    end
  end

endmodule

// File: tb/tb_pipelined_controller.sv
// Bench for pipelined_controller: three instances share one stimulus stream
// (a: MUL_CYCLES=4, b: MUL_CYCLES=1, c: CNT_W=2). Inputs change 1 time unit
// after a rising edge; outputs are checked at that same point, so each check
// sees the word registered from the inputs of the previous cycle.
module tb_pipelined_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       haz, fl;

  // clock
  always #5 clk = ~clk;

  logic a_br, a_imm, a_st, a_wb, a_mr, a_mw, a_stall, a_ill, a_dbg;
  logic [3:0] a_exe;
  logic [1:0] a_bc;
  logic [15:0] a_cnt;
  logic b_br, b_imm, b_st, b_wb, b_mr, b_mw, b_stall, b_ill, b_dbg;
  logic [3:0] b_exe;
  logic [1:0] b_bc;
  logic [15:0] b_cnt;
  logic c_br, c_imm, c_st, c_wb, c_mr, c_mw, c_stall, c_ill, c_dbg;
  logic [3:0] c_exe;
  logic [1:0] c_bc;
  logic [1:0] c_cnt;

  pipelined_controller #(.MUL_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .opCode(op), .hazard_detected(haz), .flush(fl),
    .branchEn(a_br), .Is_Imm(a_imm), .ST_or_BNE(a_st), .WB_EN(a_wb),
    .MEM_R_EN(a_mr), .MEM_W_EN(a_mw), .EXE_CMD(a_exe), .Branch_command(a_bc),
    .stall_out(a_stall), .illegal_op(a_ill), .bubble_cnt(a_cnt), .state_dbg(a_dbg));

  pipelined_controller #(.MUL_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .opCode(op), .hazard_detected(haz), .flush(fl),
    .branchEn(b_br), .Is_Imm(b_imm), .ST_or_BNE(b_st), .WB_EN(b_wb),
    .MEM_R_EN(b_mr), .MEM_W_EN(b_mw), .EXE_CMD(b_exe), .Branch_command(b_bc),
    .stall_out(b_stall), .illegal_op(b_ill), .bubble_cnt(b_cnt), .state_dbg(b_dbg));

  pipelined_controller #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .opCode(op), .hazard_detected(haz), .flush(fl),
    .branchEn(c_br), .Is_Imm(c_imm), .ST_or_BNE(c_st), .WB_EN(c_wb),
    .MEM_R_EN(c_mr), .MEM_W_EN(c_mw), .EXE_CMD(c_exe), .Branch_command(c_bc),
    .stall_out(c_stall), .illegal_op(c_ill), .bubble_cnt(c_cnt), .state_dbg(c_dbg));

  // packed word {br,imm,st,wb,mr,mw,exe[3:0],bc[1:0],ill}
  logic [12:0] a_word, b_word;
  assign a_word = {a_br, a_imm, a_st, a_wb, a_mr, a_mw, a_exe, a_bc, a_ill};
  assign b_word = {b_br, b_imm, b_st, b_wb, b_mr, b_mw, b_exe, b_bc, b_ill};

  int n_total = 0;
  int n_pass  = 0;

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [12:0] mk(input logic br, input logic imm, input logic st,
                                     input logic wb, input logic mr, input logic mw,
                                     input logic [3:0] exe, input logic [1:0] bc,
                                     input logic ill);
    return {br, imm, st, wb, mr, mw, exe, bc, ill};
  endfunction

  // driver: advance one cycle, outputs then reflect the previous inputs
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] o, input logic h, input logic f);
    op  = o;
    haz = h;
    fl  = f;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic        haz;
    logic        fl;
    logic [12:0] w;
    int          cnt;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int ccnt;
    tbl[0]  = '{6'd0,  1'b0, 1'b0, mk(0,0,0,0,0,0,4'd0,2'd0,0), 0};
    tbl[1]  = '{6'd1,  1'b0, 1'b0, mk(0,0,0,1,0,0,4'd1,2'd0,0), 0};
    tbl[2]  = '{6'd2,  1'b0, 1'b0, mk(0,0,0,1,0,0,4'd2,2'd0,0), 0};
    tbl[3]  = '{6'd3,  1'b0, 1'b0, mk(0,0,0,1,0,0,4'd3,2'd0,0), 0};
    tbl[4]  = '{6'd4,  1'b0, 1'b0, mk(0,0,0,1,0,0,4'd4,2'd0,0), 0};
    tbl[5]  = '{6'd5,  1'b0, 1'b0, mk(1,1,0,0,0,0,4'd0,2'd1,0), 0};
    tbl[6]  = '{6'd6,  1'b0, 1'b0, mk(1,1,1,0,0,0,4'd0,2'd2,0), 0};
    tbl[7]  = '{6'd7,  1'b0, 1'b0, mk(1,1,0,0,0,0,4'd0,2'd3,0), 0};
    tbl[8]  = '{6'd8,  1'b0, 1'b0, mk(0,1,0,1,1,0,4'd1,2'd0,0), 0};
    tbl[9]  = '{6'd9,  1'b0, 1'b0, mk(0,1,1,0,0,1,4'd1,2'd0,0), 0};
    tbl[10] = '{6'd8,  1'b1, 1'b0, mk(0,0,0,0,0,0,4'd0,2'd0,0), 1};
    tbl[11] = '{6'd8,  1'b1, 1'b1, mk(0,0,0,0,0,0,4'd0,2'd0,0), 2};
    tbl[12] = '{6'd63, 1'b0, 1'b0, mk(0,0,0,0,0,0,4'd0,2'd0,1), 3};
    tbl[13] = '{6'd63, 1'b0, 1'b0, mk(0,0,0,0,0,0,4'd0,2'd0,1), 4};
    tbl[14] = '{6'd1,  1'b0, 1'b0, mk(0,0,0,1,0,0,4'd1,2'd0,0), 4};
    tbl[15] = '{6'd11, 1'b0, 1'b1, mk(0,0,0,0,0,0,4'd0,2'd0,0), 5};
    tbl[16] = '{6'd0,  1'b0, 1'b0, mk(0,0,0,0,0,0,4'd0,2'd0,0), 5};

    // reset held two cycles with ADD on the opcode bus
    rst = 1'b1;
    drive(6'd1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_word", {19'd0, a_word}, 32'd0);
      chk("rst_stall", {31'd0, a_stall}, 32'd0);
      chk("rst_cnt", {16'd0, a_cnt}, 32'd0);
      chk("rst_state", {31'd0, a_dbg}, 32'd0);
    end
    rst = 1'b0;
    step();
    chk("post_rst_add", {19'd0, a_word}, {19'd0, mk(0,0,0,1,0,0,4'd1,2'd0,0)});

    // table: decode sweep, hazard/flush bubbles, illegal opcodes
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].op, tbl[i].haz, tbl[i].fl);
      step();
      chk($sformatf("vec%0d_word", i), {19'd0, a_word}, {19'd0, tbl[i].w});
      chk($sformatf("vec%0d_cnt", i), {16'd0, a_cnt}, tbl[i].cnt);
      chk($sformatf("vec%0d_stall", i), {31'd0, a_stall}, 32'd0);
      ccnt = (tbl[i].cnt > 3) ? 3 : tbl[i].cnt;
      chk($sformatf("vec%0d_cnt_sat", i), {30'd0, c_cnt}, ccnt);
    end

    // MUL sequencing: a (4 cycles) and b (1 cycle) side by side
    drive(6'd10, 1'b0, 1'b0);
    step();                                   // cycle N+1
    chk("mul_a_word", {19'd0, a_word}, {19'd0, mk(0,0,0,1,0,0,4'd5,2'd0,0)});
    chk("mul_a_stall1", {31'd0, a_stall}, 32'd1);
    chk("mul_b_word", {19'd0, b_word}, {19'd0, mk(0,0,0,1,0,0,4'd5,2'd0,0)});
    chk("mul_b_stall1", {31'd0, b_stall}, 32'd0);
    chk("mul_a_busy", {31'd0, a_dbg}, 32'd1);
    drive(6'd1, 1'b0, 1'b0);
    step();                                   // cycle N+2
    chk("mul_a_stall2", {31'd0, a_stall}, 32'd1);
    chk("mul_a_zero2", {19'd0, a_word}, 32'd0);
    chk("mul_b_add", {19'd0, b_word}, {19'd0, mk(0,0,0,1,0,0,4'd1,2'd0,0)});
    chk("mul_b_stall2", {31'd0, b_stall}, 32'd0);
    drive(6'd1, 1'b0, 1'b1);                  // flush during BUSY
    step();                                   // cycle N+3
    chk("mul_a_stall3", {31'd0, a_stall}, 32'd1);
    chk("mul_a_zero3", {19'd0, a_word}, 32'd0);
    chk("mul_a_cnt_flush_ignored", {16'd0, a_cnt}, 32'd5);
    chk("mul_b_flushed", {19'd0, b_word}, 32'd0);
    chk("mul_b_cnt", {16'd0, b_cnt}, 32'd6);
    chk("mul_b_stall3", {31'd0, b_stall}, 32'd0);
    drive(6'd1, 1'b0, 1'b0);
    step();                                   // cycle N+4
    chk("mul_a_add", {19'd0, a_word}, {19'd0, mk(0,0,0,1,0,0,4'd1,2'd0,0)});
    chk("mul_a_stall4", {31'd0, a_stall}, 32'd0);
    chk("mul_a_idle", {31'd0, a_dbg}, 32'd0);
    chk("mul_b_stall4", {31'd0, b_stall}, 32'd0);

    // mid-BUSY reset
    drive(6'd10, 1'b0, 1'b0);
    step();                                   // first BUSY cycle
    chk("mbr_stall1", {31'd0, a_stall}, 32'd1);
    drive(6'd1, 1'b0, 1'b0);
    step();                                   // second BUSY cycle
    chk("mbr_stall2", {31'd0, a_stall}, 32'd1);
    rst = 1'b1;
    step();
    chk("mbr_stall_after", {31'd0, a_stall}, 32'd0);
    chk("mbr_state", {31'd0, a_dbg}, 32'd0);
    chk("mbr_word", {19'd0, a_word}, 32'd0);
    chk("mbr_cnt", {16'd0, a_cnt}, 32'd0);
    rst = 1'b0;
    step();
    chk("mbr_add", {19'd0, a_word}, {19'd0, mk(0,0,0,1,0,0,4'd1,2'd0,0)});
    chk("mbr_add_stall", {31'd0, a_stall}, 32'd0);

    // saturation: five hazard bubbles into a 2-bit counter
    drive(6'd1, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step();
      ccnt = (i > 3) ? 3 : i;
      chk($sformatf("sat%0d_c", i), {30'd0, c_cnt}, ccnt);
      chk($sformatf("sat%0d_a", i), {16'd0, a_cnt}, i);
      chk($sformatf("sat%0d_word", i), {19'd0, a_word}, 32'd0);
    end

    // illegal pulse lasts one cycle
    drive(6'd63, 1'b0, 1'b0);
    step();
    chk("ill_pulse", {19'd0, a_word}, {19'd0, mk(0,0,0,0,0,0,4'd0,2'd0,1)});
    drive(6'd0, 1'b0, 1'b0);
    step();
    chk("ill_drop", {31'd0, a_ill}, 32'd0);
    chk("ill_cnt", {16'd0, a_cnt}, 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipelined_controller.md
# pipelined_controller

Parametrised, registered ID-stage control unit for the MIPS datapath. It decodes `opCode` into the full control word and registers it into the ID/EX boundary, one cycle of latency. It inserts bubbles on load-use hazards and branch flushes, and sequences multi-cycle `MUL` by asserting a front-end stall for a programmable number of cycles. It also flags illegal opcodes and keeps a saturating bubble counter for performance monitoring.

## Interface
Parameters:
- `OP_CODE_LEN`, default 6: opcode width.
- `EXE_CMD_LEN`, default 4: ALU command width.
- `MUL_CYCLES`, default 4: total EX occupancy of `MUL`, legal range 1..255.
- `CNT_W`, default 16: bubble counter width.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opCode`  in  `OP_CODE_LEN`  instruction opcode in ID.
- `hazard_detected`  in  1  load-use hazard; insert bubble.
- `flush`  in  1  taken branch in EX; kill the ID instruction.
- `branchEn`, `Is_Imm`, `ST_or_BNE`, `WB_EN`, `MEM_R_EN`, `MEM_W_EN`  out  1 each  registered control bits.
- `EXE_CMD`  out  `EXE_CMD_LEN`  registered ALU command.
- `Branch_command`  out  2  registered branch condition.
- `stall_out`  out  1  registered; holds PC and IF/ID while a `MUL` occupies EX.
- `illegal_op`  out  1  registered one-cycle pulse on an undefined opcode.
- `bubble_cnt`  out  `CNT_W`  saturating count of bubbles issued.

## Operation
Encodings:
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, OR=4, BEZ=5, BNE=6, JMP=7, LD=8, ST=9, MUL=10. All other values are illegal.
- EXE_CMD: NOP=0, ADD=1, SUB=2, AND=3, OR=4, MUL=5.
- Branch_command: none=0, BEZ=1, BNE=2, JUMP=3.

Decode (the registered word is all-zero except the fields listed):
- ADD, SUB, AND, OR: EXE_CMD per op, WB_EN=1.
- LD: EXE_CMD=ADD, Is_Imm=1, WB_EN=1, MEM_R_EN=1.
- ST: EXE_CMD=ADD, Is_Imm=1, ST_or_BNE=1, MEM_W_EN=1.
- BEZ: Is_Imm=1, branchEn=1, Branch_command=1.
- BNE: Is_Imm=1, branchEn=1, Branch_command=2, ST_or_BNE=1.
- JMP: Is_Imm=1, branchEn=1, Branch_command=3.
- MUL: EXE_CMD=5, WB_EN=1.
- NOP: all-zero word. This is not a bubble and is not counted.
- Illegal opcode: all-zero word, illegal_op=1 next cycle. Counted as a bubble.

State machine:
- States are IDLE and BUSY; an 8-bit down-counter `mc` tracks BUSY.
- IDLE, per-edge priority:
  - `rst`.
  - `flush`: bubble.
  - `hazard_detected`: bubble.
  - decode `opCode`.
- Decoding MUL with `MUL_CYCLES`>1 moves to BUSY and loads `mc`=`MUL_CYCLES`-1. With `MUL_CYCLES`=1 the FSM stays in IDLE.
- BUSY:
  - Output word is all-zero and `stall_out`=1.
  - `opCode`, `hazard_detected` and `flush` are ignored; flush cannot target an instruction older than the MUL.
  - `mc` decrements each cycle. When `mc`=1 the FSM returns to IDLE, so `stall_out` is low from the next cycle.
- BUSY-cycle zero words are not counted as bubbles.
- `bubble_cnt` increments by 1 per flush, hazard or illegal bubble. It saturates at 2^`CNT_W`-1.
- `rst` in any state, including mid-BUSY, aborts immediately. State goes to IDLE and all outputs go to 0.

## Timing
- Reset value: every output is 0, the state is IDLE, `mc`=0 and `bubble_cnt`=0.
- Latency: `opCode` sampled at edge N appears on the outputs after edge N, i.e. during cycle N+1.
- A MUL sampled at edge N:
  - Its control word is valid in cycle N+1.
  - `stall_out`=1 in cycles N+1 .. N+`MUL_CYCLES`-1.
  - The next opcode is decoded at edge N+`MUL_CYCLES`-1 and is visible in cycle N+`MUL_CYCLES`.
- `flush` and `hazard_detected` asserted together produce one bubble and one count increment.
- `illegal_op` lasts exactly one cycle per illegal sample. Back-to-back illegal opcodes keep it high continuously.

## Test plan
- Reset: assert `rst` for 2 cycles with opCode=1. Required: all outputs 0, `bubble_cnt`=0. Then release `rst`; required: EXE_CMD=1 and WB_EN=1 one cycle later.
- Decode sweep: drive opcodes 0..10 on consecutive cycles. Required: each registered word matches the Operation list one cycle later. BNE must give Branch_command=2, ST_or_BNE=1, Is_Imm=1.
- Hazard and flush:
  - opCode=8 (LD) with `hazard_detected`=1 → zero word, `bubble_cnt`=1.
  - Next cycle, `flush`=1 together with `hazard_detected`=1 → zero word, `bubble_cnt`=2.
- MUL sequencing, `MUL_CYCLES`=4:
  - MUL at edge N → EXE_CMD=5 in cycle N+1.
  - `stall_out`=1 in cycles N+1..N+3. A `flush` asserted in cycle N+2 is ignored.
  - ADD held on `opCode` appears in cycle N+4. Repeat with `MUL_CYCLES`=1: `stall_out` never rises.
- Mid-BUSY reset: MUL, then `rst` in the second BUSY cycle. Required: `stall_out`=0 the next cycle and the state is IDLE. A following ADD decodes normally.
- Illegal and saturation:
  - opCode=63 → `illegal_op`=1 for one cycle, zero word.
  - With `CNT_W`=2, five hazard bubbles → `bubble_cnt` holds at 3.
